tmvp_top: RTL and testbench



---
 rtl/tmvp_pkg.sv | 20 ++
 rtl/tmvp_dual_port_ram.sv | 28 ++
 rtl/tmvp_mac_lane.sv | 27 ++
 rtl/tmvp_top.sv | 238 +++++++++++++++++++++++
 tb/tb_tmvp_top.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/tmvp_pkg.sv
// Shared constants, FSM state encoding and coefficient type for the TMVP engine.
package tmvp_pkg;

  localparam int N_DEF      = 512;
  localparam int REAL_N_DEF = 509;
  localparam int TILE_DEF   = 16;
  localparam int DW_DEF     = 8;
  localparam int ADDR_W     = $clog2(N_DEF);

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    MAC,
    DRAIN,
    FINISH
  } state_t;

  typedef logic [DW_DEF-1:0] coef_t;

endpackage

// File: rtl/tmvp_dual_port_ram.sv
// Dual-port synchronous RAM/ROM with one-cycle registered read.
module tmvp_dual_port_ram #(
  parameter int    DATA_WIDTH   = 8,
  parameter int    ADDR_WIDTH   = 9,
  parameter string INITIAL_FILE = ""
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Both ports: optional write, registered read (read-before-write).
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/tmvp_mac_lane.sv
// One multiply-accumulate lane: acc <- acc + a*b, all truncated to DATA_WIDTH.
module tmvp_mac_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] acc
);

  logic [DATA_WIDTH-1:0] acc_reg;

  // Accumulator: cleared on reset or per-tile clear, otherwise wraps mod 2^DATA_WIDTH.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + a * b;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/tmvp_top.sv
// Tiled Toeplitz-matrix-vector product: h = f*g mod (x^REAL_N - 1), streamed in index order.
module tmvp_top
  import tmvp_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int REAL_N     = REAL_N_DEF,
  parameter int TILE_SIZE  = TILE_DEF,
  parameter int DATA_WIDTH = DW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic [$clog2(N)-1:0]  bram_f_address_a,
  output logic [$clog2(N)-1:0]  bram_f_address_b,
  input  logic [DATA_WIDTH-1:0] bram_f_data_out_a,
  input  logic [DATA_WIDTH-1:0] bram_f_data_out_b,
  output logic [$clog2(N)-1:0]  bram_g_address_a,
  output logic [$clog2(N)-1:0]  bram_g_address_b,
  input  logic [DATA_WIDTH-1:0] bram_g_data_out_a,
  input  logic [DATA_WIDTH-1:0] bram_g_data_out_b,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid
);

  localparam int AW = $clog2(N);
  localparam int IW = AW + 1;               // room for b+TILE_SIZE and wrap compares
  localparam int LW = $clog2(TILE_SIZE);
  localparam logic [IW-1:0] REAL_N_I   = IW'(REAL_N);
  localparam logic [IW-1:0] TILE_I     = IW'(TILE_SIZE);
  localparam logic [IW-1:0] HALF_I     = IW'(TILE_SIZE / 2);
  // Preload: TILE_SIZE/2 pair fetches, plus two cycles of ROM latency during
  // which the first two MAC operands are issued ahead.
  localparam logic [IW-1:0] PRE_LAST_I = IW'(TILE_SIZE / 2 + 1);

  state_t state_reg, state_next;
  logic [IW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0] base_reg, base_next;       // tile base b
  logic [IW-1:0] pre_idx_reg, pre_idx_next; // next g word to preload
  logic [IW-1:0] gw_idx_reg, gw_idx_next;   // next g word shifted into w[0]
  logic [IW-1:0] f_idx_reg, f_idx_next;     // next f word to fetch
  logic [AW-1:0] fa_reg, fa_next, ga_reg, ga_next, gb_reg, gb_next;
  logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
  logic tvalid_reg, tvalid_next, done_reg, done_next;

  logic [DATA_WIDTH-1:0] win_reg  [TILE_SIZE];
  logic [DATA_WIDTH-1:0] win_next [TILE_SIZE];
  logic [DATA_WIDTH-1:0] acc      [TILE_SIZE];

  logic [IW-1:0] rem, last_lane;
  logic last_tile, pre_shift, mac_step, lane_clear;
  logic unused_bits;

  // Index helpers: modular wrap by compare/subtract only.
  function automatic logic [IW-1:0] add_mod(input logic [IW-1:0] x, input logic [IW-1:0] s);
    logic [IW-1:0] y;
    y = x + s;
    if (y >= REAL_N_I) y = y - REAL_N_I;
    return y;
  endfunction

  function automatic logic [IW-1:0] dec_mod(input logic [IW-1:0] x);
    return (x == '0) ? REAL_N_I - IW'(1) : x - IW'(1);
  endfunction

  assign rem        = REAL_N_I - base_reg;
  assign last_tile  = (rem <= TILE_I);
  assign last_lane  = last_tile ? rem - IW'(1) : TILE_I - IW'(1);
  assign pre_shift  = (state_reg == PRELOAD) && (cnt_reg >= IW'(2));
  assign mac_step   = (state_reg == MAC);
  assign lane_clear = (state_reg == PRELOAD);

  // Next-state and datapath control; every _next defaults to hold.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    base_next    = base_reg;
    pre_idx_next = pre_idx_reg;
    gw_idx_next  = gw_idx_reg;
    f_idx_next   = f_idx_reg;
    fa_next      = fa_reg;
    ga_next      = ga_reg;
    gb_next      = gb_reg;
    tdata_next   = tdata_reg;
    tvalid_next  = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = PRELOAD;
          cnt_next     = '0;
          base_next    = '0;
          pre_idx_next = '0;
          gw_idx_next  = REAL_N_I - IW'(1);
          f_idx_next   = '0;
        end
      end
      PRELOAD: begin
        if (cnt_reg < HALF_I) begin
          ga_next      = AW'(pre_idx_reg);
          gb_next      = AW'(add_mod(pre_idx_reg, IW'(1)));
          pre_idx_next = add_mod(pre_idx_reg, IW'(2));
        end else begin
          fa_next     = AW'(f_idx_reg);
          f_idx_next  = f_idx_reg + IW'(1);
          ga_next     = AW'(gw_idx_reg);
          gw_idx_next = dec_mod(gw_idx_reg);
        end
        if (cnt_reg == PRE_LAST_I) begin
          state_next = MAC;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + IW'(1);
        end
      end
      MAC: begin
        // f fetches stop at REAL_N-1 so padding words are never read.
        if (f_idx_reg < REAL_N_I) begin
          fa_next    = AW'(f_idx_reg);
          f_idx_next = f_idx_reg + IW'(1);
        end
        ga_next     = AW'(gw_idx_reg);
        gw_idx_next = dec_mod(gw_idx_reg);
        if (cnt_reg == REAL_N_I - IW'(1)) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + IW'(1);
        end
      end
      DRAIN: begin
        tdata_next  = acc[cnt_reg[LW-1:0]];
        tvalid_next = 1'b1;
        if (cnt_reg == last_lane) begin
          cnt_next = '0;
          if (last_tile) begin
            state_next = FINISH;
          end else begin
            state_next   = PRELOAD;
            base_next    = base_reg + TILE_I;
            pre_idx_next = base_reg + TILE_I;
            gw_idx_next  = base_reg + TILE_I - IW'(1);
            f_idx_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + IW'(1);
        end
      end
      FINISH: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      base_reg    <= '0;
      pre_idx_reg <= '0;
      gw_idx_reg  <= '0;
      f_idx_reg   <= '0;
      fa_reg      <= '0;
      ga_reg      <= '0;
      gb_reg      <= '0;
      tdata_reg   <= '0;
      tvalid_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      base_reg    <= base_next;
      pre_idx_reg <= pre_idx_next;
      gw_idx_reg  <= gw_idx_next;
      f_idx_reg   <= f_idx_next;
      fa_reg      <= fa_next;
      ga_reg      <= ga_next;
      gb_reg      <= gb_next;
      tdata_reg   <= tdata_next;
      tvalid_reg  <= tvalid_next;
      done_reg    <= done_next;
    end
  end

  // Window next values: preload shifts pairs down from the top, MAC shifts up by one.
  genvar gi;
  generate
    for (gi = 0; gi < TILE_SIZE; gi++) begin : g_win
      logic [DATA_WIDTH-1:0] pre_in, mac_in;
      if (gi < TILE_SIZE - 2) begin : g_pre_mid
        assign pre_in = win_reg[gi+2];
      end else if (gi == TILE_SIZE - 2) begin : g_pre_a
        assign pre_in = bram_g_data_out_a;
      end else begin : g_pre_b
        assign pre_in = bram_g_data_out_b;
      end
      if (gi == 0) begin : g_mac_in
        assign mac_in = bram_g_data_out_a;
      end else begin : g_mac_shift
        assign mac_in = win_reg[gi-1];
      end
      assign win_next[gi] = pre_shift ? pre_in : (mac_step ? mac_in : win_reg[gi]);

      tmvp_mac_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .clk   (clk),
        .reset (reset),
        .clear (lane_clear),
        .en    (mac_step),
        .a     (bram_f_data_out_a),
        .b     (win_reg[gi]),
        .acc   (acc[gi])
      );
    end
  endgenerate

  // Window register bank.
  always_ff @(posedge clk) begin
    for (int k = 0; k < TILE_SIZE; k++) begin
      if (!reset) win_reg[k] <= '0;
      else        win_reg[k] <= win_next[k];
    end
  end

  assign unused_bits      = ^bram_f_data_out_b;
  assign ready            = (state_reg == IDLE);
  assign done             = done_reg;
  assign m_axis_tdata     = tdata_reg;
  assign m_axis_tvalid    = tvalid_reg;
  assign bram_f_address_a = fa_reg;
  assign bram_f_address_b = '0;
  assign bram_g_address_a = ga_reg;
  assign bram_g_address_b = gb_reg;

endmodule

// File: tb/tb_tmvp_top.sv
// Directed bench for tmvp_top: hand-computed coefficient table, full-product model, control corners.
module tb_tmvp_top;
  import tmvp_pkg::*;

  localparam int R      = 509;
  localparam int BUDGET = 20000;
  localparam int LAT_MAX = (512 / 16) * (509 + 16 + 16);

  logic clk = 1'b0;
  logic reset, start, ready, done, tvalid;
  logic [ADDR_W-1:0] f_addr_a, f_addr_b, g_addr_a, g_addr_b;
  coef_t f_q_a, f_q_b, g_q_a, g_q_b, tdata;

  coef_t f_mem [512];
  coef_t g_mem [512];
  coef_t out_mem [5][512];

  typedef struct {
    int    job;
    int    idx;
    coef_t exp;
  } vec_t;
  vec_t vecs [16];

  int checks = 0;
  int errors = 0;
  int bad_addr = 0;

  always #5 clk = ~clk;

  tmvp_top dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .ready             (ready),
    .done              (done),
    .bram_f_address_a  (f_addr_a),
    .bram_f_address_b  (f_addr_b),
    .bram_f_data_out_a (f_q_a),
    .bram_f_data_out_b (f_q_b),
    .bram_g_address_a  (g_addr_a),
    .bram_g_address_b  (g_addr_b),
    .bram_g_data_out_a (g_q_a),
    .bram_g_data_out_b (g_q_b),
    .m_axis_tdata      (tdata),
    .m_axis_tvalid     (tvalid)
  );

  // ROM models: one-cycle registered read.
  always @(posedge clk) begin
    f_q_a <= f_mem[f_addr_a];
    f_q_b <= f_mem[f_addr_b];
    g_q_a <= g_mem[g_addr_a];
    g_q_b <= g_mem[g_addr_b];
  end

  // Padding words must never be addressed by the read ports in use.
  always @(negedge clk) begin
    if (reset && (f_addr_a >= ADDR_W'(R) || g_addr_a >= ADDR_W'(R) || g_addr_b >= ADDR_W'(R)))
      bad_addr++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int n, input int j, input int i, input int e);
    vecs[n].job = j;
    vecs[n].idx = i;
    vecs[n].exp = coef_t'(e);
  endtask

  // mode 0 shift, 1 all-ones, 2 overflow, 3 identity; padding filled with junk
  task automatic fill(input int mode);
    for (int i = 0; i < 512; i++) begin
      f_mem[i] = 8'h77;
      g_mem[i] = 8'h5A;
    end
    for (int i = 0; i < R; i++) begin
      f_mem[i] = 8'd0;
      g_mem[i] = (mode == 0 || mode == 3) ? coef_t'(i % 256) : 8'd0;
      if (mode == 1) begin
        f_mem[i] = 8'd1;
        g_mem[i] = 8'd1;
      end
    end
    if (mode == 0) f_mem[1] = 8'd1;
    if (mode == 2) begin
      f_mem[0] = 8'd255;
      g_mem[0] = 8'd255;
    end
    if (mode == 3) f_mem[0] = 8'd1;
  endtask

  // Cyclic convolution straight from the definition.
  task automatic check_model(input int jid);
    int    bad   = 0;
    int    first = -1;
    coef_t e;
    for (int i = 0; i < R; i++) begin
      e = 8'd0;
      for (int j = 0; j < R; j++) e = coef_t'(e + f_mem[j] * g_mem[(i - j + R) % R]);
      if (out_mem[jid][i] !== e) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    check($sformatf("job%0d_model_mismatches(first idx %0d)", jid, first), bad, 0);
  endtask

  // Start a job at the current negedge and collect its stream until done.
  task automatic run_job(input int jid, input bit busy_pulse);
    int n = 0;
    int cycles = 1;
    bit seen_done = 0;
    bit prev_v = 0;
    bit order_ok = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen_done && cycles < BUDGET) begin
      if (tvalid) begin
        if (n < 512) out_mem[jid][n] = tdata;
        n++;
      end
      if (done) begin
        seen_done = 1;
        order_ok  = prev_v && !tvalid;
      end
      prev_v = tvalid;
      start = (busy_pulse && (cycles == 60 || cycles == 9000)) ? 1'b1 : 1'b0;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    $display("job %0d: %0d coefficients, done seen=%0d after %0d cycles", jid, n, seen_done, cycles);
    check($sformatf("job%0d_done_seen", jid), int'(seen_done), 1);
    check($sformatf("job%0d_tvalid_count", jid), n, R);
    check($sformatf("job%0d_done_after_last_tvalid", jid), int'(order_ok), 1);
    check($sformatf("job%0d_latency_in_bound", jid), int'(cycles <= LAT_MAX), 1);
    check($sformatf("job%0d_done_single_pulse", jid), int'(done), 0);
    check($sformatf("job%0d_ready_after_done", jid), int'(ready), 1);
    check_model(jid);
  endtask

  initial begin
    int early_n;
    int after_v;

    set_vec(0, 0, 0, 252);  set_vec(1, 0, 1, 0);    set_vec(2, 0, 300, 43);
    set_vec(3, 0, 508, 251); set_vec(4, 1, 0, 253); set_vec(5, 1, 16, 253);
    set_vec(6, 1, 508, 253); set_vec(7, 2, 0, 1);   set_vec(8, 2, 1, 0);
    set_vec(9, 2, 508, 0);  set_vec(10, 3, 0, 0);   set_vec(11, 3, 255, 255);
    set_vec(12, 3, 256, 0); set_vec(13, 3, 508, 252); set_vec(14, 4, 508, 252);
    set_vec(15, 4, 17, 17);

    for (int j = 0; j < 5; j++)
      for (int i = 0; i < 512; i++) out_mem[j][i] = 8'hEE;

    reset = 1'b0;
    start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check("reset_ready", int'(ready), 1);
    check("reset_done", int'(done), 0);
    check("reset_tvalid", int'(tvalid), 0);
    check("reset_tdata", int'(tdata), 0);
    check("reset_addresses", int'({f_addr_a, f_addr_b, g_addr_a, g_addr_b}), 0);
    reset = 1'b1;
    @(negedge clk);

    // Shift pattern, with start pulses while busy that must be ignored.
    run_job(0, 1'b1);

    // Reset in the MAC phase of the third tile: two tiles already streamed.
    fill(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    early_n = 0;
    repeat (1200) begin
      if (tvalid) early_n++;
      @(negedge clk);
    end
    check("pre_reset_tvalid_count", early_n, 32);
    reset = 1'b0;
    @(negedge clk);
    check("midjob_reset_ready", int'(ready), 1);
    check("midjob_reset_tvalid", int'(tvalid), 0);
    reset = 1'b1;
    after_v = 0;
    repeat (40) begin
      @(negedge clk);
      if (tvalid) after_v++;
    end
    check("post_reset_no_tvalid", after_v, 0);
    $display("reset mid-job: %0d coefficients before abort, %0d after", early_n, after_v);

    // Restart after abort: all-ones.
    run_job(1, 1'b0);

    fill(2);
    run_job(2, 1'b0);

    // Identity, then a back-to-back start the cycle after done.
    fill(3);
    run_job(3, 1'b0);
    run_job(4, 1'b0);

    for (int v = 0; v < 16; v++) begin
      check($sformatf("vec%0d_job%0d_h[%0d]", v, vecs[v].job, vecs[v].idx),
            int'(out_mem[vecs[v].job][vecs[v].idx]), int'(vecs[v].exp));
    end

    begin
      int diff = 0;
      for (int i = 0; i < R; i++) if (out_mem[4][i] !== out_mem[3][i]) diff++;
      check("back_to_back_identical", diff, 0);
    end
    check("padding_never_addressed", bad_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
